// File: rtl/irqarb.sv
// Interrupt arbiter: pends per-source events onto four BR lines and
// answers the CPU acknowledge handshake with the granted source's vector.
module irqarb #(
  parameter logic [15:0] LEVELS = 16'h0000,
  parameter logic [71:0] VECS   = 72'h0
) (
  input  logic       clk,
  input  logic       busrst,
  input  logic [7:0] irq,
  output logic [3:0] irqlines,
  input  logic       iackreq,
  input  logic [1:0] iacklvl,
  output logic       iackack,
  output logic [8:0] iackvec,
  output logic       iacknone,
  output logic [7:0] pend
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [7:0] clr;
  logic       found;
  logic [2:0] sel;
  logic [8:0] sel_vec;
  logic [3:0] lines_nx;

  // Lowest index wins: scan high to low so the last hit is the lowest.
  always_comb begin
    found = 1'b0;
    sel   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pend[i] && LEVELS[2*i +: 2] == iacklvl) begin
        found = 1'b1;
        sel   = 3'(i);
      end
    end
  end

  always_comb begin
    sel_vec = VECS[9*sel +: 9];
    sel_vec[1:0] = 2'b00;
  end

  always_comb begin
    clr = 8'h00;
    if (state == LOOKUP && found) clr[sel] = 1'b1;
  end

  always_comb begin
    lines_nx = 4'h0;
    for (int i = 0; i < 8; i++) begin
      lines_nx[LEVELS[2*i +: 2]] = lines_nx[LEVELS[2*i +: 2]] | pend[i];
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (iackreq) state_nx = LOOKUP;
      LOOKUP:  state_nx = ACK;
      ACK:     if (!iackreq) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge busrst) begin
    if (busrst) state <= IDLE;
    else        state <= state_nx;
  end

  // A new event in the same cycle as its grant keeps the flag set.
  always_ff @(posedge clk or posedge busrst) begin
    if (busrst) pend <= 8'h00;
    else        pend <= (pend & ~clr) | irq;
  end

  always_ff @(posedge clk or posedge busrst) begin
    if (busrst) irqlines <= 4'h0;
    else        irqlines <= lines_nx;
  end

  always_ff @(posedge clk or posedge busrst) begin
    if (busrst) begin
      iackack  <= 1'b0;
      iackvec  <= 9'h000;
      iacknone <= 1'b0;
    end else begin
      unique case (state)
        LOOKUP: begin
          iackack  <= 1'b1;
          iackvec  <= found ? sel_vec : 9'h000;
          iacknone <= ~found;
        end
        ACK: begin
          if (!iackreq) begin
            iackack  <= 1'b0;
            iackvec  <= 9'h000;
            iacknone <= 1'b0;
          end
        end
        default: begin
          iackack <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irqarb.sv
// Self-checking bench for irqarb: scoreboard of expected acknowledge
// results plus inline checks on pending flags and request lines.
module tb_irqarb;

  logic       clk = 1'b0;
  logic       busrst;
  logic [7:0] irq;
  logic [3:0] irqlines;
  logic       iackreq;
  logic [1:0] iacklvl;
  logic       iackack;
  logic [8:0] iackvec;
  logic       iacknone;
  logic [7:0] pend;

  localparam logic [15:0] LV = 16'h0082;
  localparam logic [71:0] VC = {36'h0, 9'o300, 9'o000, 9'o060, 9'o100};

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];

  irqarb #(.LEVELS(LV), .VECS(VC)) dut (
    .clk(clk), .busrst(busrst), .irq(irq), .irqlines(irqlines),
    .iackreq(iackreq), .iacklvl(iacklvl), .iackack(iackack),
    .iackvec(iackvec), .iacknone(iacknone), .pend(pend)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_irq(input logic [7:0] v);
    irq = v;
    step();
    irq = 8'h00;
    step();
  endtask

  task automatic do_iack(input logic [1:0] lvl, input logic [8:0] v,
                         input logic n, input logic [7:0] lk_irq);
    int cyc;
    logic [9:0] e;
    exp_q.push_back({n, v});
    iacklvl = lvl;
    iackreq = 1'b1;
    step();
    irq = lk_irq;
    cyc = 0;
    while (!iackack && cyc < 8) begin
      step();
      irq = 8'h00;
      cyc++;
    end
    irq = 8'h00;
    checks++;
    if (cyc !== 1) begin
      errors++;
      $display("FAIL ack_latency got %0d cycles after lookup want 1", cyc);
    end
    e = exp_q.pop_front();
    checks++;
    if ({iacknone, iackvec} !== e) begin
      errors++;
      $display("FAIL ack_result got none=%0b vec=%o want none=%0b vec=%o",
               iacknone, iackvec, e[9], e[8:0]);
    end
    iackreq = 1'b0;
    step();
    checks++;
    if (iackack !== 1'b0 || iackvec !== 9'h000) begin
      errors++;
      $display("FAIL ack_release got ack=%0b vec=%o want 0 0",
               iackack, iackvec);
    end
  endtask

  task automatic test_reset();
    busrst = 1'b1;
    irq = 8'hff;
    iackreq = 1'b0;
    iacklvl = 2'd0;
    step();
    step();
    checks++;
    if (pend !== 8'h00 || irqlines !== 4'h0 || iackack !== 1'b0 ||
        iackvec !== 9'h000 || iacknone !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got pend=%b lines=%b ack=%0b vec=%o none=%0b want zeros",
               pend, irqlines, iackack, iackvec, iacknone);
    end
    irq = 8'h00;
    busrst = 1'b0;
    step();
  endtask

  task automatic test_single();
    irq = 8'h01;
    step();
    irq = 8'h00;
    checks++;
    if (pend !== 8'h01 || irqlines !== 4'h0) begin
      errors++;
      $display("FAIL single_pend got pend=%b lines=%b want 00000001 0000",
               pend, irqlines);
    end
    step();
    checks++;
    if (irqlines !== 4'b0100) begin
      errors++;
      $display("FAIL single_lines got %b want 0100", irqlines);
    end
    do_iack(2'd2, 9'o100, 1'b0, 8'h00);
    checks++;
    if (pend !== 8'h00 || irqlines !== 4'h0) begin
      errors++;
      $display("FAIL single_clear got pend=%b lines=%b want 0 0",
               pend, irqlines);
    end
  endtask

  task automatic test_tie();
    pulse_irq(8'b0000_1001);
    do_iack(2'd2, 9'o100, 1'b0, 8'h00);
    checks++;
    if (pend !== 8'b0000_1000) begin
      errors++;
      $display("FAIL tie_pend got %b want 00001000", pend);
    end
    do_iack(2'd2, 9'o300, 1'b0, 8'h00);
    checks++;
    if (pend !== 8'h00) begin
      errors++;
      $display("FAIL tie_pend2 got %b want 00000000", pend);
    end
  endtask

  task automatic test_isolation();
    pulse_irq(8'b0000_0011);
    checks++;
    if (irqlines !== 4'b0101) begin
      errors++;
      $display("FAIL iso_lines_pre got %b want 0101", irqlines);
    end
    do_iack(2'd0, 9'o060, 1'b0, 8'h00);
    checks++;
    if (pend !== 8'h01 || irqlines !== 4'b0100) begin
      errors++;
      $display("FAIL iso_after got pend=%b lines=%b want 00000001 0100",
               pend, irqlines);
    end
    do_iack(2'd2, 9'o100, 1'b0, 8'h00);
  endtask

  task automatic test_passive();
    pulse_irq(8'b0000_0010);
    do_iack(2'd3, 9'o000, 1'b1, 8'h00);
    checks++;
    if (pend !== 8'b0000_0010) begin
      errors++;
      $display("FAIL passive_pend got %b want 00000010", pend);
    end
    do_iack(2'd0, 9'o060, 1'b0, 8'h00);
  endtask

  task automatic test_set_wins();
    pulse_irq(8'h01);
    do_iack(2'd2, 9'o100, 1'b0, 8'h01);
    checks++;
    if (pend !== 8'h01 || irqlines[2] !== 1'b1) begin
      errors++;
      $display("FAIL setwins got pend=%b line2=%b want 00000001 1",
               pend, irqlines[2]);
    end
    do_iack(2'd2, 9'o100, 1'b0, 8'h00);
  endtask

  task automatic test_reset_mid_ack();
    int cyc;
    pulse_irq(8'b0000_0011);
    iacklvl = 2'd0;
    iackreq = 1'b1;
    cyc = 0;
    while (!iackack && cyc < 8) begin
      step();
      cyc++;
    end
    checks++;
    if (iackack !== 1'b1 || iackvec !== 9'o060) begin
      errors++;
      $display("FAIL rst_pre_ack got ack=%0b vec=%o want 1 060",
               iackack, iackvec);
    end
    #2;
    busrst = 1'b1;
    #1;
    checks++;
    if (iackack !== 1'b0 || pend !== 8'h00 || irqlines !== 4'h0) begin
      errors++;
      $display("FAIL rst_async got ack=%0b pend=%b lines=%b want 0 0 0",
               iackack, pend, irqlines);
    end
    step();
    busrst = 1'b0;
    iackreq = 1'b0;
    step();
    pulse_irq(8'b0000_1000);
    do_iack(2'd2, 9'o300, 1'b0, 8'h00);
    checks++;
    if (pend !== 8'h00) begin
      errors++;
      $display("FAIL rst_resume got pend=%b want 0", pend);
    end
  endtask

  initial begin
    busrst = 1'b1;
    irq = 8'h00;
    iackreq = 1'b0;
    iacklvl = 2'd0;
    test_reset();
    test_single();
    test_tie();
    test_isolation();
    test_passive();
    test_set_wins();
    test_reset_mid_ack();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_left got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
